i2c_write_master: RTL

- Bit-level I2C master that executes one 3-byte write transaction per request: device address/R-W byte, register byte, data byte.
- Sits directly downstream of the audio-codec configuration sequencer. It takes a 24-bit word plus a start strobe, drives the codec's I2C bus, and returns a completion pulse with an aggregate acknowledge flag.
- Write-only. No clock stretching, no multi-master arbitration.

---
 rtl/i2c_write_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_write_master.sv
// Write-only I2C master: START, three bytes each followed by an ACK slot, then STOP, all from one start strobe.
// Takes 113 quarter-bit periods, with done one cycle after the last one. A start is taken only in IDLE; starts arriving while busy are ignored.
module i2c_write_master #(
    parameter int QUARTER = 125,
    parameter int QW      = 7
) (
    input  logic        clk,
    input  logic        reset,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat,
    input  logic [23:0] i2c_data,
    input  logic        start,
    output logic        done,
    output logic        ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BITS  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   shift_q, shift_d;
    logic          ack_fail_q, ack_fail_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          sclk_q, sclk_d;
    logic          sda_oe_q, sda_oe_d;
    logic          sda_meta_q, sda_sync_q;
    logic          tick;

    function automatic logic is_ack_slot(input logic [4:0] b);
        return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
    endfunction

    assign tick = (qcnt_q == QLAST);

    always_comb begin
        state_d    = state_q;
        qcnt_d     = '0;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ack_fail_d = ack_fail_q;
        ack_d      = ack_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        if (state_q != IDLE && !tick) begin
            qcnt_d = qcnt_q + QW'(1);
        end

        case (state_q)
            IDLE: begin
                // The done cycle is already IDLE, but a start there is still refused.
                if (start && !done_q) begin
                    shift_d    = i2c_data;
                    ack_fail_d = 1'b0;
                    ack_d      = 1'b0;
                    phase_d    = 2'd0;
                    bit_d      = 5'd0;
                    busy_d     = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    if (phase_q == 2'd1) begin
                        phase_d = 2'd0;
                        state_d = BITS;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            BITS: begin
                if (tick) begin
                    if (phase_q == 2'd2 && is_ack_slot(bit_q) && sda_sync_q) begin
                        ack_fail_d = 1'b1;
                    end
                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        if (!is_ack_slot(bit_q)) begin
                            shift_d = {shift_q[22:0], 1'b0};
                        end
                        if (bit_q == 5'd26) begin
                            bit_d   = 5'd0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (phase_q == 2'd2) begin
                        phase_d = 2'd0;
                        done_d  = 1'b1;
                        ack_d   = ~ack_fail_q;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus pins are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        sclk_d   = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            START: begin
                sclk_d   = (phase_d == 2'd0);
                sda_oe_d = 1'b1;
            end
            BITS: begin
                sclk_d   = phase_d[1];
                sda_oe_d = !is_ack_slot(bit_d) && !shift_d[23];
            end
            STOP: begin
                sclk_d   = (phase_d != 2'd0);
                sda_oe_d = (phase_d != 2'd2);
            end
            default: begin
                sclk_d   = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            qcnt_q     <= '0;
            phase_q    <= 2'd0;
            bit_q      <= 5'd0;
            shift_q    <= 24'd0;
            ack_fail_q <= 1'b0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b1;
            sda_oe_q   <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ack_fail_q <= ack_fail_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            sda_oe_q   <= sda_oe_d;
            sda_meta_q <= i2c_sdat;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign i2c_sclk = sclk_q;
    assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
    assign done     = done_q;
    assign ack      = ack_q;
    assign busy     = busy_q;

endmodule
